updown_modn_counter: RTL and testbench

UPDOWN_MODN_COUNTER -- requirements
Module: updown_modn_counter

---
 rtl/updown_modn_counter.sv | 77 +++++++
 tb/tb_updown_modn_counter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/updown_modn_counter.sv
// Up/down modulo-MOD counter with wrap/saturate boundary modes, parallel load,
// cascade carry (tc) and a sticky out-of-range-load error flag.
module updown_modn_counter #(
  parameter int WIDTH = 4,
  parameter int MOD   = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] a,
  input  logic             up,
  input  logic             sat,
  input  logic             clr_err,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             at_limit,
  output logic             err
);

  // One extra bit so MOD == 2**WIDTH is representable for the range check.
  localparam logic [WIDTH:0]   MODX = (WIDTH+1)'(MOD);
  localparam logic [WIDTH-1:0] TOP  = WIDTH'(MOD - 1);

  logic at_top;
  logic at_bot;
  logic at_bound;
  logic a_ok;

  assign at_top   = (count == TOP);
  assign at_bot   = (count == '0);
  assign at_bound = up ? at_top : at_bot;
  assign tc       = en & at_bound;
  assign a_ok     = ({1'b0, a} < MODX);

  always_ff @(posedge clk) begin
    if (!rst) begin
      count    <= '0;
      wrap     <= 1'b0;
      at_limit <= 1'b0;
      err      <= 1'b0;
    end else begin
      // Setting the error takes precedence over clearing it on the same edge.
      if (load && !a_ok)
        err <= 1'b1;
      else if (clr_err)
        err <= 1'b0;

      if (load) begin
        count    <= a_ok ? a : '0;
        wrap     <= 1'b0;
        at_limit <= 1'b0;
      end else if (en) begin
        if (at_bound) begin
          if (sat) begin
            wrap     <= 1'b0;
            at_limit <= 1'b1;
          end else begin
            count    <= up ? '0 : TOP;
            wrap     <= 1'b1;
            at_limit <= 1'b0;
          end
        end else begin
          count    <= up ? count + WIDTH'(1) : count - WIDTH'(1);
          wrap     <= 1'b0;
          at_limit <= 1'b0;
        end
      end else begin
        wrap <= 1'b0;
      end
    end
  end

  count_in_range: assert property (@(posedge clk) disable iff (!rst) ({1'b0, count} < MODX));

endmodule

// File: tb/tb_updown_modn_counter.sv
// Directed self-checking bench for updown_modn_counter: single stage (MOD=12),
// natural-binary stage (MOD=16) and a two-stage MOD=12 cascade.
module tb_updown_modn_counter;

  logic       clk = 1'b0;
  logic       rst, en, load, up, sat, clr_err;
  logic [3:0] a;
  logic [3:0] count;
  logic       tc, wrap, at_limit, err;

  logic       en16;
  logic [3:0] count16;
  logic       tc16, wrap16, at_limit16, err16;

  logic       casEn;
  logic [3:0] c0, c1;
  logic       tc0, tc1, wrap0, wrap1, lim0, lim1, err0, err1;

  int testsRun  = 0;
  int testsFail = 0;

  always #5 clk = ~clk;

  updown_modn_counter #(.WIDTH(4), .MOD(12)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .a(a), .up(up), .sat(sat),
    .clr_err(clr_err), .count(count), .tc(tc), .wrap(wrap), .at_limit(at_limit), .err(err)
  );

  updown_modn_counter #(.WIDTH(4), .MOD(16)) dut16 (
    .clk(clk), .rst(rst), .en(en16), .load(1'b0), .a(4'd0), .up(1'b1), .sat(1'b0),
    .clr_err(1'b0), .count(count16), .tc(tc16), .wrap(wrap16), .at_limit(at_limit16), .err(err16)
  );

  updown_modn_counter #(.WIDTH(4), .MOD(12)) stage0 (
    .clk(clk), .rst(rst), .en(casEn), .load(1'b0), .a(4'd0), .up(1'b1), .sat(1'b0),
    .clr_err(1'b0), .count(c0), .tc(tc0), .wrap(wrap0), .at_limit(lim0), .err(err0)
  );

  updown_modn_counter #(.WIDTH(4), .MOD(12)) stage1 (
    .clk(clk), .rst(rst), .en(tc0), .load(1'b0), .a(4'd0), .up(1'b1), .sat(1'b0),
    .clr_err(1'b0), .count(c1), .tc(tc1), .wrap(wrap1), .at_limit(lim1), .err(err1)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Inputs are already set; advance one rising edge and settle just after it.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int expC;
    int c1Steps;
    int c0Wraps;
    logic [3:0] prevC1;

    rst = 1'b0; en = 1'b0; load = 1'b0; up = 1'b1; sat = 1'b0; clr_err = 1'b0; a = 4'd0;
    en16 = 1'b0; casEn = 1'b0;

    // Reset state
    applyStimulus();
    checkOutput("rst_count", 32'(count), 0);
    checkOutput("rst_wrap", 32'(wrap), 0);
    checkOutput("rst_at_limit", 32'(at_limit), 0);
    checkOutput("rst_err", 32'(err), 0);

    // Count up with wrap: 1..11,0,1
    rst = 1'b1; en = 1'b1; up = 1'b1; sat = 1'b0;
    for (int i = 1; i <= 13; i++) begin
      applyStimulus();
      expC = i % 12;
      checkOutput($sformatf("up_count_%0d", i), 32'(count), 32'(expC));
      checkOutput($sformatf("up_wrap_%0d", i), 32'(wrap), (i == 12) ? 1 : 0);
      checkOutput($sformatf("up_tc_%0d", i), 32'(tc), (expC == 11) ? 1 : 0);
    end

    // Load 5, then count down with wrap: 4,3,2,1,0,11
    load = 1'b1; a = 4'd5; en = 1'b0;
    applyStimulus();
    checkOutput("load5_count", 32'(count), 5);
    load = 1'b0; en = 1'b1; up = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      applyStimulus();
      expC = (i == 6) ? 11 : 5 - i;
      checkOutput($sformatf("dn_count_%0d", i), 32'(count), 32'(expC));
      checkOutput($sformatf("dn_wrap_%0d", i), 32'(wrap), (i == 6) ? 1 : 0);
      checkOutput($sformatf("dn_tc_%0d", i), 32'(tc), (expC == 0) ? 1 : 0);
    end

    // Saturate at 11, then reverse direction
    up = 1'b1; sat = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      applyStimulus();
      checkOutput($sformatf("sat_count_%0d", i), 32'(count), 11);
      checkOutput($sformatf("sat_limit_%0d", i), 32'(at_limit), 1);
      checkOutput($sformatf("sat_wrap_%0d", i), 32'(wrap), 0);
      checkOutput($sformatf("sat_tc_%0d", i), 32'(tc), 1);
    end
    up = 1'b0;
    applyStimulus();
    checkOutput("rev_count", 32'(count), 10);
    checkOutput("rev_limit", 32'(at_limit), 0);

    // Out-of-range load and sticky error
    sat = 1'b0; en = 1'b0; load = 1'b1; a = 4'd13;
    applyStimulus();
    checkOutput("bad_load_count", 32'(count), 0);
    checkOutput("bad_load_err", 32'(err), 1);
    load = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      applyStimulus();
      checkOutput($sformatf("err_sticky_%0d", i), 32'(err), 1);
    end
    load = 1'b1; a = 4'd14; clr_err = 1'b1;
    applyStimulus();
    checkOutput("err_set_wins", 32'(err), 1);
    checkOutput("err_set_wins_count", 32'(count), 0);
    load = 1'b0;
    applyStimulus();
    checkOutput("err_cleared", 32'(err), 0);
    clr_err = 1'b0;

    // Load overrides enable
    en = 1'b1; up = 1'b1; load = 1'b1; a = 4'd9;
    applyStimulus();
    checkOutput("load_over_en", 32'(count), 9);

    // Reset mid-count overrides load
    en = 1'b0; a = 4'd15;
    applyStimulus();
    checkOutput("set_err_again", 32'(err), 1);
    a = 4'd7;
    applyStimulus();
    checkOutput("load7_count", 32'(count), 7);
    rst = 1'b0; a = 4'd3; en = 1'b1;
    applyStimulus();
    checkOutput("midrst_count", 32'(count), 0);
    checkOutput("midrst_err", 32'(err), 0);
    checkOutput("midrst_wrap", 32'(wrap), 0);
    checkOutput("midrst_limit", 32'(at_limit), 0);
    rst = 1'b1; en = 1'b0; load = 1'b0;
    applyStimulus();
    checkOutput("post_rst_hold", 32'(count), 0);

    // A modulus equal to 2**WIDTH wraps like plain binary
    en16 = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      applyStimulus();
      checkOutput($sformatf("m16_count_%0d", i), 32'(count16), 32'(i % 16));
      checkOutput($sformatf("m16_wrap_%0d", i), 32'(wrap16), (i == 16) ? 1 : 0);
    end
    en16 = 1'b0;

    // Two-stage cascade over 144 edges
    casEn = 1'b1;
    c1Steps = 0;
    c0Wraps = 0;
    for (int i = 1; i <= 144; i++) begin
      prevC1 = c1;
      applyStimulus();
      if (c1 != prevC1) c1Steps++;
      if (wrap0) c0Wraps++;
      checkOutput($sformatf("cascade_%0d", i), 32'({c1, c0}), 32'({4'((i / 12) % 12), 4'(i % 12)}));
    end
    checkOutput("cascade_stage1_steps", 32'(c1Steps), 12);
    checkOutput("cascade_stage0_wraps", 32'(c0Wraps), 12);
    casEn = 1'b0;

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
    $finish;
  end

endmodule
